// File: rtl/multicycle_mem_pkg.sv
// Shared definitions for the multicycle memory block.
// Holds the FSM encoding and parameter defaults.
package multicycle_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDR_W_DEFAULT  = 10;
    localparam int LATENCY_DEFAULT = 4;
    localparam int DATA_W          = 16;
    localparam int CNT_W           = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, registered read.
// Contents and read register are never reset.
module mem_array
    import multicycle_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port and read register share the same word address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/multicycle_mem.sv
// Fixed-latency memory front end: accepts one request,
// completes it LATENCY cycles later with a done pulse.
module multicycle_mem
    import multicycle_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [15:0] IDX_MASK = 16'(((1 << ADDR_W) - 1) << 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               wr_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               done_q;
    logic               rd_valid;
    logic               finish;
    logic               accept;
    logic [DATA_W-1:0]  mem_q;
    logic               unused_addr;

    // Byte bit and bits above the word index alias away
    assign unused_addr = ^(addr & ~IDX_MASK);

    // Last BUSY edge: commit write or capture read
    assign finish = (state == BUSY) && (cnt == 4'd1);
    assign accept = req && ((state == IDLE) || (state == DONE));

    // Control FSM, latency counter and request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state   <= BUSY;
                        cnt     <= CNT_LOAD;
                        wr_q    <= wr;
                        idx_q   <= addr[ADDR_W:1];
                        wdata_q <= wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (finish) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        if (!wr_q) begin
                            rd_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (finish && wr_q),
        .re     (finish && !wr_q),
        .addr   (idx_q),
        .wdata  (wdata_q),
        .rdata  (mem_q)
    );

    assign busy  = (state == BUSY);
    assign done  = done_q;
    // Unreset read register is hidden until a read has completed
    assign rdata = rd_valid ? mem_q : '0;

endmodule

// File: tb/tb_multicycle_mem.sv
// Self-checking bench for multicycle_mem.
// Randomized traffic against a word-array reference model.
module tb_multicycle_mem;

    localparam int LAT   = 4;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem   [DEPTH];
    bit          ref_valid [DEPTH];
    logic [15:0] ref_rdata;
    bit          ref_known;

    always #5 clk = ~clk;

    multicycle_mem #(
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .rdata (rdata)
    );

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    // One request; ends at the negedge where done is observed.
    task automatic run_op(input string name, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input bit from_done, input bit noise);
        bit eb;
        bit ed;
        if (!from_done) @(negedge clk);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            eb = (k < LAT);
            ed = (k == LAT);
            if (k == LAT) begin
                if (w) begin
                    ref_mem[widx(a)]   = d;
                    ref_valid[widx(a)] = 1'b1;
                end else begin
                    ref_known = ref_valid[widx(a)];
                    ref_rdata = ref_mem[widx(a)];
                end
            end
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("FAIL %s busy k=%0d: got %b expected %b",
                         name, k, busy, eb);
            end
            n_checks++;
            if (done !== ed) begin
                n_fail++;
                $display("FAIL %s done k=%0d: got %b expected %b",
                         name, k, done, ed);
            end
            if (ref_known) begin
                n_checks++;
                if (rdata !== ref_rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata k=%0d: got %h expected %h",
                             name, k, rdata, ref_rdata);
                end
            end
            if (noise && k < LAT) begin
                req   = 1'b1;
                wr    = 1'($urandom);
                addr  = 16'($urandom);
                wdata = 16'($urandom);
            end
        end
        req = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s quiet: got busy=%b done=%b expected 0 0",
                     name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy: got %b expected 0", busy);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset done: got %b expected 0", done);
        end
        n_checks++;
        if (rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset rdata: got %h expected 0000", rdata);
        end
        rst_n     = 1'b1;
        ref_rdata = 16'h0000;
        ref_known = 1'b1;
    endtask

    task automatic test_write_read();
        run_op("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
        check_quiet("wr_beef_after");
        run_op("rd_0010", 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
        run_op("rd_0011", 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0);
        check_quiet("rd_after");
    endtask

    task automatic test_back_to_back();
        run_op("b2b_wr", 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0);
        run_op("b2b_rd", 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0);
        check_quiet("b2b_after");
    endtask

    task automatic test_busy_ignore();
        run_op("ign_rd", 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1);
        check_quiet("ign_after");
        run_op("ign_chk", 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        run_op("ab_wr1", 1'b1, 16'h0030, 16'hAAAA, 1'b0, 1'b0);
        @(negedge clk);
        req   = 1'b1;
        wr    = 1'b1;
        addr  = 16'h0030;
        wdata = 16'h5555;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort in reset: got %b %b %h expected 0 0 0000",
                     busy, done, rdata);
        end
        ref_rdata = 16'h0000;
        ref_known = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            check_quiet("abort_no_done");
        end
        run_op("ab_rd", 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_alias();
        run_op("al_wr", 1'b1, 16'h0802, 16'h7777, 1'b0, 1'b0);
        run_op("al_rd", 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int pool [8];
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            pool[i] = int'($urandom_range(64, DEPTH - 1));
            a = 16'(pool[i] << 1);
            run_op("rnd_init", 1'b1, a, 16'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            a = (16'($urandom) & 16'hF801) |
                16'(pool[$urandom_range(0, 7)] << 1);
            run_op("rnd", 1'($urandom), a, 16'($urandom),
                   1'($urandom), 1'($urandom));
        end
        check_quiet("rnd_end");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_alias();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_mem.md
MULTICYCLE_MEM -- requirements
Module: multicycle_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (storage depth 2^ADDR_W words of 16 bits).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to completion pulse; legal range 2..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  request strobe from the CPU-side initiator.
REQ-006 SHALL have port wr  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  16  byte address; word index = addr[ADDR_W:1]; addr[0] and bits above ADDR_W ignored (aliasing).
REQ-008 SHALL have port wdata  input  16  write data; sampled with req.
REQ-009 SHALL have port busy  output  1  high while a request is in flight (state BUSY); initiator stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse for both reads and writes.
REQ-011 SHALL have port rdata  output  16  read result; valid in the done cycle of a read; holds value until next read completion.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL accept a request on an edge where req=1 and state is IDLE or DONE; accepted addr/wr/wdata latched; state -> BUSY; down-counter loaded with LATENCY-1.
REQ-014 SHALL ignore req while in BUSY (no queueing, no error); initiator re-issues after done.
REQ-015 In BUSY, counter decrements each edge; at the edge where counter==1, state -> DONE.
REQ-016 done SHALL be 1 exactly in DONE; with acceptance at edge N, done is high in the cycle after edge N+LATENCY-1 (LATENCY cycles after acceptance).
REQ-017 Write SHALL commit to storage on the edge entering DONE; read SHALL sample storage on that same edge into rdata.
REQ-018 A read accepted in the DONE cycle of a write to the same word SHALL return the new data.
REQ-019 From DONE with req=0, state -> IDLE; with req=1, new request accepted (back-to-back throughput one op per LATENCY cycles).
REQ-020 Write completion SHALL NOT modify rdata.
REQ-021 busy = (state==BUSY); combinational decode of state, no glitch-sensitive logic.

Reset
REQ-022 On rst_n=0 (asynchronous): state IDLE, counter 0, busy 0, done 0, rdata 16'h0000, latched request cleared.
REQ-023 Reset during BUSY SHALL abort the operation: a pending write is not committed, no done pulse follows.
REQ-024 Storage contents SHALL NOT be reset; reads of never-written words return undefined data.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding (2-bit IDLE=0, BUSY=1, DONE=2) and defaults for ADDR_W and LATENCY.
REQ-026 Storage SHALL be a sub-module mem_array: synchronous write enable, registered synchronous read, no reset, 2^ADDR_W x 16.
REQ-027 Top level SHALL contain only FSM, counter, request latch and output logic.

Verification
REQ-028 Reset then write addr=16'h0010 wdata=16'hBEEF, LATENCY=4 -> busy 3 cycles, done pulses 4 cycles after acceptance, rdata stays 16'h0000.
REQ-029 Read addr=16'h0010 after REQ-028 -> done after 4 cycles with rdata=16'hBEEF; addr=16'h0011 returns same word.
REQ-030 Write 16'h1234 to 16'h0020, req held high in its DONE cycle with read 16'h0020 -> read accepted without IDLE gap, returns 16'h1234.
REQ-031 req pulses during BUSY with different addr -> ignored; exactly one done, data from first request.
REQ-032 Write 16'hAAAA to 16'h0030, then write 16'h5555 to same word and assert rst_n=0 mid-BUSY -> no done; subsequent read returns 16'hAAAA.
REQ-033 ADDR_W=10: write 16'h7777 to addr 16'h0802 -> read of 16'h0002 returns 16'h7777 (aliasing).
